// File: rtl/mcycle_muldiv.sv
// rtl/mcycle_muldiv.sv - multi-cycle unsigned shift-add multiplier / restoring divider
module mcycle_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Start,
    input  logic             MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy,
    output logic             Done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE,
        COMPUTING
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]      count;
    logic               op_div;
    logic [2*WIDTH-1:0] acc, mcand;
    logic [WIDTH-1:0]   mplier, rem, quo, divisor;

    logic               start_ok, last;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH:0]     shifted;
    logic               ge;
    logic [WIDTH-1:0]   rem_next, quo_next;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= state_next;
    end

    // Done gates acceptance so the stalled instruction's held Start cannot re-trigger.
    always_comb begin
        state_next = state;
        Busy       = 1'b0;
        start_ok   = 1'b0;
        last       = (count == CW'(WIDTH - 1));
        case (state)
            IDLE: begin
                if (Start && !Done) begin
                    start_ok   = 1'b1;
                    state_next = COMPUTING;
                    Busy       = ~RESET;
                end
            end
            COMPUTING: begin
                Busy = ~RESET;
                if (last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // One iteration of each algorithm; the final edge commits these next values directly.
    always_comb begin
        acc_next = acc + (mplier[0] ? mcand : '0);
        shifted  = {rem, quo[WIDTH-1]};
        ge       = (shifted >= {1'b0, divisor});
        rem_next = ge ? (shifted[WIDTH-1:0] - divisor) : shifted[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], ge};
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            count   <= '0;
            op_div  <= 1'b0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            rem     <= '0;
            quo     <= '0;
            divisor <= '0;
            Result1 <= '0;
            Result2 <= '0;
            Done    <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (start_ok) begin
                count   <= '0;
                op_div  <= MCycleOp;
                acc     <= '0;
                mcand   <= {{WIDTH{1'b0}}, Operand1};
                mplier  <= Operand2;
                rem     <= '0;
                quo     <= Operand1;
                divisor <= Operand2;
            end else if (state == COMPUTING) begin
                count <= count + 1'b1;
                if (op_div) begin
                    rem <= rem_next;
                    quo <= quo_next;
                end else begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                end
                // A zero divisor naturally yields all-ones quotient and remainder = dividend.
                if (last) begin
                    Result1 <= op_div ? quo_next : acc_next[WIDTH-1:0];
                    Result2 <= op_div ? rem_next : acc_next[2*WIDTH-1:WIDTH];
                    Done    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mcycle_muldiv.sv
// tb/tb_mcycle_muldiv.sv - self-checking bench for mcycle_muldiv
module tb_mcycle_muldiv;

    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         Start;
    logic         MCycleOp;
    logic [W-1:0] Operand1;
    logic [W-1:0] Operand2;
    logic [W-1:0] Result1;
    logic [W-1:0] Result2;
    logic         Busy;
    logic         Done;

    int checks   = 0;
    int failures = 0;

    mcycle_muldiv #(.WIDTH(W)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .Start    (Start),
        .MCycleOp (MCycleOp),
        .Operand1 (Operand1),
        .Operand2 (Operand2),
        .Result1  (Result1),
        .Result2  (Result2),
        .Busy     (Busy),
        .Done     (Done)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Returns {Result2, Result1} from plain arithmetic.
    function automatic logic [63:0] model(input logic op, input logic [31:0] a, input logic [31:0] b);
        if (!op)        return {32'd0, a} * {32'd0, b};
        else if (b == 0) return {a, 32'hFFFF_FFFF};
        else            return {a % b, a / b};
    endfunction

    task automatic run_op(input string tag, input logic op, input logic [31:0] a,
                          input logic [31:0] b, input bit hold, input bit perturb);
        logic [63:0] exp;
        int          busy_cnt;
        bit          got_done;
        exp = model(op, a, b);
        @(negedge CLK);
        MCycleOp = op;
        Operand1 = a;
        Operand2 = b;
        Start    = 1'b1;
        #1;
        chk({tag, " busy_in_start_cycle"}, 64'(Busy), 64'd1);
        busy_cnt = 1;
        got_done = 1'b0;
        @(posedge CLK);
        #1;
        if (!hold) Start = 1'b0;
        for (int c = 0; c < 100 && !got_done; c++) begin
            @(negedge CLK);
            if (perturb && c == 5) begin
                Operand1 = ~a;
                Operand2 = b + 32'd7;
                MCycleOp = ~op;
                Start    = 1'b1;
            end
            if (perturb && c == 6 && !hold) Start = 1'b0;
            #1;
            if (Done)      got_done = 1'b1;
            else if (Busy) busy_cnt++;
            else break;
        end
        chk({tag, " done_seen"}, 64'(got_done), 64'd1);
        chk({tag, " busy_cycles"}, 64'(busy_cnt), 64'(W + 1));
        chk({tag, " busy_in_done_cycle"}, 64'(Busy), 64'd0);
        chk({tag, " result"}, {Result2, Result1}, exp);
        // Instruction still presents Start during writeback; it must not re-trigger.
        Start = 1'b1;
        #1;
        chk({tag, " busy_with_start_in_done"}, 64'(Busy), 64'd0);
        @(posedge CLK);
        #1;
        Start = 1'b0;
        @(negedge CLK);
        #1;
        chk({tag, " no_restart_busy"}, 64'(Busy), 64'd0);
        chk({tag, " done_one_cycle"}, 64'(Done), 64'd0);
        chk({tag, " result_hold"}, {Result2, Result1}, exp);
    endtask

    initial begin
        bit          seen;
        logic        rop;
        logic [31:0] ra, rb;

        RESET    = 1'b1;
        Start    = 1'b0;
        MCycleOp = 1'b0;
        Operand1 = '0;
        Operand2 = '0;
        #2;
        chk("reset busy", 64'(Busy), 64'd0);
        chk("reset done", 64'(Done), 64'd0);
        chk("reset results", {Result2, Result1}, 64'd0);
        @(negedge CLK);
        RESET = 1'b0;

        run_op("mul_7x6", 1'b0, 32'd7, 32'd6, 1'b1, 1'b0);
        chk("mul_7x6 direct", {Result2, Result1}, 64'd42);
        run_op("mul_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        chk("mul_max direct", {Result2, Result1}, 64'hFFFF_FFFE_0000_0001);
        run_op("div_100_7", 1'b1, 32'd100, 32'd7, 1'b1, 1'b0);
        chk("div_100_7 direct", {Result2, Result1}, {32'd2, 32'd14});
        run_op("div_msb_1", 1'b1, 32'h8000_0000, 32'd1, 1'b0, 1'b0);
        chk("div_msb_1 direct", {Result2, Result1}, {32'd0, 32'h8000_0000});
        run_op("div_by_zero", 1'b1, 32'd5, 32'd0, 1'b1, 1'b0);
        chk("div_by_zero direct", {Result2, Result1}, {32'd5, 32'hFFFF_FFFF});

        // Abort a multiply after ten iterations.
        @(negedge CLK);
        MCycleOp = 1'b0;
        Operand1 = 32'h1234;
        Operand2 = 32'h5678;
        Start    = 1'b1;
        @(posedge CLK);
        #1;
        Start = 1'b0;
        repeat (10) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        chk("abort busy", 64'(Busy), 64'd0);
        chk("abort done", 64'(Done), 64'd0);
        chk("abort results", {Result2, Result1}, 64'd0);
        @(negedge CLK);
        RESET = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            #1;
            if (Done || Busy) seen = 1'b1;
        end
        chk("abort no_done_after", 64'(seen), 64'd0);
        run_op("mul_after_abort", 1'b0, 32'h1234, 32'h5678, 1'b0, 1'b0);
        chk("mul_after_abort direct", {Result2, Result1}, 64'h0626_0060);

        run_op("perturb_mul", 1'b0, 32'hDEAD_BEEF, 32'h0001_2345, 1'b0, 1'b1);
        run_op("perturb_div", 1'b1, 32'hCAFE_F00D, 32'd1234, 1'b1, 1'b1);

        for (int i = 0; i < 10; i++) begin
            rop = 1'($urandom_range(0, 1));
            ra  = $urandom;
            case (i % 4)
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 255));
                default: rb = $urandom;
            endcase
            run_op($sformatf("rand%0d", i), rop, ra, rb, 1'(i % 2), 1'(i % 3 == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
